dmem_port_arbiter: RTL and testbench

Shares the single data-memory port (address, write data, byte-op, write-enable, read data) between the pipelined CPU's MEM stage and one auxiliary requester such as a program loader or debug master. Grants one requester per cycle, stalls the CPU when it loses arbitration, and routes the one-cycle-latency read data back to whichever requester issued the read. A bounded starvation counter guarantees the auxiliary port progress against a continuously accessing CPU.

---
 rtl/dmem_port_arbiter.sv | 97 +++++++++
 tb/tb_dmem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU MEM stage vs. one auxiliary master.
// CPU has priority; a saturating starvation counter forces aux through.
module dmem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [2:0]  cpu_op,
   output logic        cpu_stall,
   output logic [31:0] cpu_rdata,
   output logic        cpu_rvalid,
   input  logic        aux_req,
   input  logic        aux_we,
   input  logic [31:0] aux_addr,
   input  logic [31:0] aux_wdata,
   input  logic [2:0]  aux_op,
   output logic        aux_gnt,
   output logic [31:0] aux_rdata,
   output logic        aux_rvalid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_datain,
   output logic [2:0]  mem_op,
   output logic        mem_we,
   input  logic [31:0] mem_dataout
);

   localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_AUX  = 2'd2;

   logic [3:0] starve_q, starve_d;
   logic [1:0] own_q, own_d;
   logic       cpu_grant, aux_grant, force_aux;

   assign force_aux = (starve_q >= LIMIT);
   assign aux_grant = aux_req & (~cpu_req | force_aux);
   assign cpu_grant = cpu_req & ~aux_grant;

   assign cpu_stall = cpu_req & ~cpu_grant;
   assign aux_gnt   = aux_grant;

   always_comb begin
      mem_addr   = '0;
      mem_datain = '0;
      mem_op     = '0;
      mem_we     = 1'b0;
      if (cpu_grant) begin
         mem_addr   = cpu_addr;
         mem_datain = cpu_wdata;
         mem_op     = cpu_op;
         mem_we     = cpu_we;
      end else if (aux_grant) begin
         mem_addr   = aux_addr;
         mem_datain = aux_wdata;
         mem_op     = aux_op;
         mem_we     = aux_we;
      end
   end

   // Counter only grows while aux is actively waiting; any gap resets it.
   always_comb begin
      starve_d = '0;
      if (aux_req & ~aux_grant) begin
         starve_d = force_aux ? LIMIT : starve_q + 4'd1;
      end
   end

   always_comb begin
      own_d = OWN_NONE;
      if (cpu_grant & ~cpu_we) begin
         own_d = OWN_CPU;
      end else if (aux_grant & ~aux_we) begin
         own_d = OWN_AUX;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q <= '0;
         own_q    <= OWN_NONE;
      end else begin
         starve_q <= starve_d;
         own_q    <= own_d;
      end
   end

   assign cpu_rvalid = (own_q == OWN_CPU);
   assign aux_rvalid = (own_q == OWN_AUX);
   assign cpu_rdata  = mem_dataout;
   assign aux_rdata  = mem_dataout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios then random traffic,
// grant/mux checked each cycle, read returns checked by a scoreboard monitor.
module tb_dmem_port_arbiter;

   localparam int LIM = 4;

   typedef struct {
      bit          req;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  op;
   } req_t;

   typedef struct {
      int          due;
      bit          aux;
      logic [31:0] data;
   } rd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 0, cpu_we = 0;
   logic [31:0] cpu_addr = 0, cpu_wdata = 0;
   logic [2:0]  cpu_op = 0;
   logic        cpu_stall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        aux_req = 0, aux_we = 0;
   logic [31:0] aux_addr = 0, aux_wdata = 0;
   logic [2:0]  aux_op = 0;
   logic        aux_gnt, aux_rvalid;
   logic [31:0] aux_rdata;
   logic [31:0] mem_addr, mem_datain;
   logic [2:0]  mem_op;
   logic        mem_we;
   logic [31:0] mem_dataout = 0;

   dmem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_op(cpu_op),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
      .cpu_rvalid(cpu_rvalid),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
      .aux_wdata(aux_wdata), .aux_op(aux_op),
      .aux_gnt(aux_gnt), .aux_rdata(aux_rdata),
      .aux_rvalid(aux_rvalid),
      .mem_addr(mem_addr), .mem_datain(mem_datain),
      .mem_op(mem_op), .mem_we(mem_we),
      .mem_dataout(mem_dataout)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          waits = 0;
   bit          mon_en = 0;
   rd_t         rq[$];
   logic [31:0] mem [logic [31:0]];
   logic [31:0] next_dout = 0;
   bit          last_cw = 0, last_aw = 0;
   req_t        c, a, idle;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mread(input logic [31:0] ad);
      if (mem.exists(ad)) return mem[ad];
      return ad ^ 32'hC3A5_0000;
   endfunction

   // One cycle: apply requests at negedge, check the combinational
   // outputs against the arbitration rules, then advance the model.
   task automatic step(input req_t cr, input req_t ar);
      bit aw, cw;
      req_t g;
      @(negedge clk);
      cyc++;
      mem_dataout = next_dout;
      cpu_req = cr.req; cpu_we = cr.we; cpu_addr = cr.addr;
      cpu_wdata = cr.wdata; cpu_op = cr.op;
      aux_req = ar.req; aux_we = ar.we; aux_addr = ar.addr;
      aux_wdata = ar.wdata; aux_op = ar.op;
      #1;
      aw = ar.req && (!cr.req || waits >= LIM);
      cw = cr.req && !aw;
      g = cw ? cr : (aw ? ar : idle);
      chk("aux_gnt", 32'(aux_gnt), 32'(aw));
      chk("cpu_stall", 32'(cpu_stall), 32'(cr.req && !cw));
      chk("mem_we", 32'(mem_we), 32'(g.req && g.we));
      chk("mem_addr", mem_addr, g.req ? g.addr : 32'h0);
      chk("mem_datain", mem_datain, g.req ? g.wdata : 32'h0);
      chk("mem_op", 32'(mem_op), g.req ? 32'(g.op) : 32'h0);
      next_dout = $urandom;
      if (g.req && !g.we) begin
         next_dout = mread(g.addr);
         rq.push_back('{due: cyc + 1, aux: aw, data: next_dout});
      end
      if (g.req && g.we) mem[g.addr] = g.wdata;
      if (ar.req && !aw) waits = (waits >= LIM) ? LIM : waits + 1;
      else waits = 0;
      last_cw = cw;
      last_aw = aw;
   endtask

   function automatic req_t mk(input bit r, input bit w,
                               input logic [31:0] ad,
                               input logic [31:0] wd,
                               input logic [2:0] op);
      req_t t;
      t.req = r; t.we = w; t.addr = ad; t.wdata = wd; t.op = op;
      return t;
   endfunction

   function automatic req_t rnd(input int pct);
      req_t t;
      t.req   = ($urandom_range(0, 99) < pct);
      t.we    = $urandom_range(0, 2) == 0;
      t.addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      t.wdata = $urandom;
      t.op    = 3'($urandom_range(0, 7));
      return t;
   endfunction

   // Scoreboard monitor: pops the pending read due this cycle.
   initial begin
      wait (mon_en);
      forever begin
         bit ev, ea;
         @(negedge clk);
         #2;
         ev = (rq.size() > 0) && (rq[0].due == cyc);
         ea = ev && rq[0].aux;
         chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ev && !ea));
         chk("aux_rvalid", 32'(aux_rvalid), 32'(ea));
         if (ev) begin
            if (ea) chk("aux_rdata", aux_rdata, rq[0].data);
            else    chk("cpu_rdata", cpu_rdata, rq[0].data);
            void'(rq.pop_front());
         end
         while (rq.size() > 0 && rq[0].due <= cyc) begin
            chk("stale_read", 32'(rq[0].due), 32'(cyc + 1));
            void'(rq.pop_front());
         end
      end
   end

   initial begin
      idle = mk(0, 0, 0, 0, 0);
      #3;
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
      chk("rst_aux_rvalid", 32'(aux_rvalid), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      #19 rst = 1'b1;
      mon_en = 1;

      mem[32'h100] = 32'hDEAD_BEEF;
      step(mk(1, 0, 32'h100, 0, 3'b010), idle);
      step(idle, mk(1, 1, 32'h40, 32'h1234_5678, 3'b010));
      step(idle, idle);
      chk("store_written", mread(32'h40), 32'h1234_5678);

      // Continuous contention: four CPU wins, then a forced aux grant.
      for (int i = 0; i < 10; i++) begin
         step(mk(1, 0, 32'(i * 4), 0, 3'b010),
              mk(1, 1, 32'h80, 32'hA0A0_0000 + i / 5, 3'b010));
         chk("pattern_aux", 32'(last_aw), 32'(i % 5 == 4));
      end
      step(idle, idle);

      // Alternating loads: CPU 0x10 on its 4th win, aux 0x20 forced next.
      for (int i = 0; i < 5; i++)
         step(mk(1, 0, (i == 3) ? 32'h10 : 32'h30, 0, 3'b010),
              mk(1, 0, 32'h20, 0, 3'b010));
      chk("alt_forced", 32'(last_aw), 1);
      step(idle, idle);
      step(idle, idle);

      // Aux gives up after 3 denials, then must wait a full window.
      for (int i = 0; i < 3; i++)
         step(mk(1, 1, 32'h8, 1, 0), mk(1, 0, 32'h24, 0, 0));
      step(mk(1, 1, 32'h8, 1, 0), idle);
      for (int i = 0; i < 5; i++) begin
         step(mk(1, 1, 32'h8, 1, 0), mk(1, 0, 32'h24, 0, 0));
         chk("rereq_aux", 32'(last_aw), 32'(i == 4));
      end
      step(idle, idle);

      // Reset lands between a CPU load and its return.
      step(mk(1, 0, 32'h100, 0, 3'b010), mk(1, 0, 32'h28, 0, 0));
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_mid_rvalid", 32'(cpu_rvalid), 0);
      #1 rst = 1'b1;
      rq.delete();
      waits = 0;
      step(idle, idle);
      for (int i = 0; i < 5; i++) begin
         step(mk(1, 0, 32'h4, 0, 0), mk(1, 0, 32'h28, 0, 0));
         chk("post_rst_aux", 32'(last_aw), 32'(i == 4));
      end

      // Random traffic; a losing requester holds its fields.
      c = idle;
      a = idle;
      for (int i = 0; i < 800; i++) begin
         req_t nc, na;
         nc = (c.req && !last_cw) ? c : rnd(70);
         na = (a.req && !last_aw) ? a : rnd(40);
         c = nc;
         a = na;
         step(c, a);
      end
      step(idle, idle);
      step(idle, idle);
      @(negedge clk);
      #3;
      chk("queue_drained", 32'(rq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
